// File: rtl/sisc_ctrl_fsm.sv
// rtl/sisc_ctrl_fsm.sv - SISC multi-cycle control FSM with HALT, stall and retire counter.
// Optional: SISC_MEM_WAIT_EN adds dm_ready and a variable-length MEM state.
module sisc_ctrl_fsm #(
    parameter int OP_W   = 4,
    parameter int CC_W   = 4,
    parameter int AM_IMM = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [OP_W-1:0]  opcode,
    input  logic [CC_W-1:0]  mm,
    input  logic [CC_W-1:0]  stat,
    input  logic             stall,
`ifdef SISC_MEM_WAIT_EN
    input  logic             dm_ready,
`endif
    output logic             rf_we,
    output logic             ir_load,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             pc_rst,
    output logic             br_sel,
    output logic             rb_sel,
    output logic             dm_we,
    output logic             mux_16_sel,
    output logic             mux4_swap_sel,
    output logic [1:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [OP_W-1:0] OP_LOD = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STR = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SWP = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BRA = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BRR = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BNR = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ALU = OP_W'(8);
    localparam logic [OP_W-1:0] OP_HLT = {OP_W{1'b1}};

    // 4-bit encoding leaves spare codes so a corrupted state is detectable
    typedef enum logic [3:0] {
        ST_START0    = 4'd0,
        ST_START1    = 4'd1,
        ST_FETCH     = 4'd2,
        ST_DECODE    = 4'd3,
        ST_EXECUTE   = 4'd4,
        ST_MEM       = 4'd5,
        ST_WRITEBACK = 4'd6,
        ST_HALT      = 4'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic is_lod, is_str, is_swp, is_alu, is_hlt, is_abs_br, is_rel_br, is_br;
    logic cond_hit, taken, imm, hold;

    assign is_lod    = (opcode == OP_LOD);
    assign is_str    = (opcode == OP_STR);
    assign is_swp    = (opcode == OP_SWP);
    assign is_alu    = (opcode == OP_ALU);
    assign is_hlt    = (opcode == OP_HLT);
    assign is_abs_br = (opcode == OP_BRA) || (opcode == OP_BNE);
    assign is_rel_br = (opcode == OP_BRR) || (opcode == OP_BNR);
    assign is_br     = is_abs_br || is_rel_br;
    assign cond_hit  = |(stat & mm);
    assign taken     = ((opcode == OP_BRA) || (opcode == OP_BRR)) ? cond_hit : !cond_hit;
    assign imm       = (mm == CC_W'(AM_IMM));
    assign hold      = stall && (state_q inside {ST_FETCH, ST_DECODE, ST_EXECUTE,
                                                 ST_MEM, ST_WRITEBACK});
    assign retired   = retired_q;

`ifdef SISC_MEM_WAIT_EN
    logic mem_done_q, mem_done_d;
`endif

    always_comb begin
        state_d       = state_q;
        retired_d     = retired_q;
        rf_we         = 1'b0;
        ir_load       = 1'b0;
        pc_write      = 1'b0;
        pc_sel        = 1'b0;
        pc_rst        = 1'b0;
        br_sel        = 1'b0;
        rb_sel        = 1'b0;
        dm_we         = 1'b0;
        mux_16_sel    = 1'b0;
        mux4_swap_sel = 1'b0;
        alu_op        = 2'b00;
        wb_sel        = 2'b00;
        halted        = 1'b0;
        case (state_q)
            ST_START0: begin
                pc_rst  = 1'b1;
                alu_op  = 2'b10;
                state_d = ST_START1;
            end
            ST_START1: state_d = ST_FETCH;
            ST_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                rb_sel = is_str || is_swp;
                if (is_br) begin
                    pc_sel   = 1'b1;
                    pc_write = taken;
                    br_sel   = is_abs_br;
                end
                state_d = is_hlt ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_alu) alu_op = imm ? 2'b01 : 2'b00;
                else        alu_op = imm ? 2'b11 : 2'b10;
                if (is_lod) wb_sel = 2'd1;
                dm_we         = is_str || is_swp;
                mux4_swap_sel = is_swp;
                state_d       = ST_MEM;
            end
            ST_MEM: begin
                if (is_lod || is_str || is_swp) mux_16_sel = imm;
`ifdef SISC_MEM_WAIT_EN
                dm_we = (is_str || is_swp) && !mem_done_q;
                if (is_swp) begin
                    wb_sel = 2'd2;
                    rf_we  = dm_ready;
                end
                if (dm_ready) state_d = ST_WRITEBACK;
`else
                dm_we = is_str || is_swp;
                if (is_swp) begin
                    wb_sel = 2'd2;
                    rf_we  = 1'b1;
                end
                state_d = ST_WRITEBACK;
`endif
            end
            ST_WRITEBACK: begin
                rf_we = is_alu || is_lod;
                if (is_lod) wb_sel = 2'd1;
                state_d   = ST_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_START0;
        endcase
        // A stalled cycle must not repeat a write that the released cycle will issue
        if (hold) begin
            state_d   = state_q;
            retired_d = retired_q;
            rf_we     = 1'b0;
            dm_we     = 1'b0;
            pc_write  = 1'b0;
            ir_load   = 1'b0;
        end
    end

`ifdef SISC_MEM_WAIT_EN
    assign mem_done_d = (state_q == ST_MEM) && (state_d == ST_MEM) && (mem_done_q || !stall);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) mem_done_q <= 1'b0;
        else        mem_done_q <= mem_done_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q   <= ST_START0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_sisc_ctrl_fsm.sv
// tb/tb_sisc_ctrl_fsm.sv - scoreboard bench for sisc_ctrl_fsm (4-bit retire counter).
module tb_sisc_ctrl_fsm;

    localparam int CNT_W = 4;

    localparam logic [14:0] RF   = 15'h4000;
    localparam logic [14:0] IR   = 15'h2000;
    localparam logic [14:0] PCW  = 15'h1000;
    localparam logic [14:0] PCS  = 15'h0800;
    localparam logic [14:0] PCR  = 15'h0400;
    localparam logic [14:0] BR   = 15'h0200;
    localparam logic [14:0] RB   = 15'h0100;
    localparam logic [14:0] DM   = 15'h0080;
    localparam logic [14:0] M16  = 15'h0040;
    localparam logic [14:0] SWS  = 15'h0020;
    localparam logic [14:0] A01  = 15'h0008;
    localparam logic [14:0] A10  = 15'h0010;
    localparam logic [14:0] A11  = 15'h0018;
    localparam logic [14:0] WB1  = 15'h0002;
    localparam logic [14:0] WB2  = 15'h0004;
    localparam logic [14:0] HLTD = 15'h0001;
    localparam logic [14:0] FE   = IR | PCW;
    localparam logic [14:0] S0   = PCR | A10;

    logic clk, rst_f, stall;
    logic [3:0] opcode, mm, stat;
    logic rf_we, ir_load, pc_write, pc_sel, pc_rst, br_sel, rb_sel, dm_we;
    logic mux_16_sel, mux4_swap_sel, halted;
    logic [1:0] alu_op, wb_sel;
    logic [CNT_W-1:0] retired;
    logic [14:0] ctl_vec;

    typedef struct {
        string           name;
        logic [14:0]     ctl;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int n_checks = 0;
    int n_errors = 0;
    logic [CNT_W-1:0] exp_ret;

    sisc_ctrl_fsm #(.OP_W(4), .CC_W(4), .AM_IMM(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .stall(stall),
`ifdef SISC_MEM_WAIT_EN
        .dm_ready(1'b1),
`endif
        .rf_we(rf_we), .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel),
        .pc_rst(pc_rst), .br_sel(br_sel), .rb_sel(rb_sel), .dm_we(dm_we),
        .mux_16_sel(mux_16_sel), .mux4_swap_sel(mux4_swap_sel), .alu_op(alu_op),
        .wb_sel(wb_sel), .halted(halted), .retired(retired)
    );

    assign ctl_vec = {rf_we, ir_load, pc_write, pc_sel, pc_rst, br_sel, rb_sel, dm_we,
                      mux_16_sel, mux4_swap_sel, alu_op, wb_sel, halted};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (ctl_vec !== mon_e.ctl || retired !== mon_e.ret) begin
                n_errors++;
                $display("FAIL %s: ctl=%b retired=%0d expected ctl=%b retired=%0d",
                         mon_e.name, ctl_vec, retired, mon_e.ctl, mon_e.ret);
            end
        end
    end

    task automatic cyc(input string n, input logic [14:0] c);
        exp_t e;
        e.name = n;
        e.ctl  = c;
        e.ret  = exp_ret;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input string n, input logic [3:0] op, input logic [3:0] m,
                         input logic [3:0] s, input logic [14:0] d, input logic [14:0] e,
                         input logic [14:0] mem, input logic [14:0] w);
        opcode = op;
        mm     = m;
        stat   = s;
        cyc({n, ".fetch"}, FE);
        cyc({n, ".decode"}, d);
        cyc({n, ".execute"}, e);
        cyc({n, ".mem"}, mem);
        cyc({n, ".writeback"}, w);
        exp_ret = exp_ret + 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_f = 1'b0; stall = 1'b0; opcode = '0; mm = '0; stat = '0;
        exp_ret = '0;
        @(posedge clk);
        #1;
        cyc("reset_start0", S0);
        rst_f = 1'b1;
        cyc("release_start0", S0);
        cyc("start1", 15'h0);

        instr("alu_imm", 4'd8, 4'd8, 4'd0, 15'h0, A01, 15'h0, RF);
        instr("alu_reg", 4'd8, 4'd0, 4'd0, 15'h0, 15'h0, 15'h0, RF);

        // reset asserted at the start of an EXECUTE cycle
        opcode = 4'd8; mm = 4'd8;
        cyc("pre_rst.fetch", FE);
        cyc("pre_rst.decode", 15'h0);
        rst_f = 1'b0;
        exp_ret = '0;
        cyc("rst_mid_exec", S0);
        cyc("rst_held", S0);
        rst_f = 1'b1;
        cyc("rst_rel_start0", S0);
        cyc("rst_rel_start1", 15'h0);

        instr("bra_taken", 4'd4, 4'b0010, 4'b0010, PCW | PCS | BR, A10, 15'h0, 15'h0);
        instr("bra_not", 4'd4, 4'b0010, 4'b0000, PCS | BR, A10, 15'h0, 15'h0);
        instr("bnr_taken", 4'd7, 4'b0001, 4'b0000, PCW | PCS, A10, 15'h0, 15'h0);
        instr("swp_imm", 4'd3, 4'd8, 4'd0, RB, A11 | DM | SWS, M16 | DM | WB2 | RF, 15'h0);

        opcode = 4'd1; mm = 4'd0; stat = 4'd0;
        cyc("lod.fetch", FE);
        cyc("lod.decode", 15'h0);
        cyc("lod.execute", A10 | WB1);
        cyc("lod.mem", 15'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc("lod.wb_stalled", WB1);
        stall = 1'b0;
        cyc("lod.wb_release", RF | WB1);
        exp_ret = exp_ret + 1'b1;

        instr("str_imm", 4'd2, 4'd8, 4'd0, RB, A11 | DM, M16 | DM, 15'h0);
        instr("noop", 4'd0, 4'd0, 4'd0, 15'h0, A10, 15'h0, 15'h0);
        instr("undef9", 4'd9, 4'd3, 4'd3, 15'h0, A10, 15'h0, 15'h0);

        stall = 1'b1;
        cyc("fetch_stalled", 15'h0);
        cyc("fetch_stalled", 15'h0);
        stall = 1'b0;
        instr("alu_after_stall", 4'd8, 4'd0, 4'd0, 15'h0, 15'h0, 15'h0, RF);

        while (exp_ret != 4'hF) instr("fill_noop", 4'd0, 4'd0, 4'd0, 15'h0, A10, 15'h0, 15'h0);
        instr("alu_wrap", 4'd8, 4'd8, 4'd0, 15'h0, A01, 15'h0, RF);

        opcode = 4'hF; mm = 4'd0; stat = 4'd0;
        cyc("hlt.fetch", FE);
        cyc("hlt.decode", 15'h0);
        for (int i = 0; i < 20; i++) begin
            stall = i[0];
            cyc("halt_hold", HLTD);
        end
        stall = 1'b0;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
